ap_tag_resolver: RTL and testbench
==================================

// Module: ap_tag_resolver
// PURPOSE
//  Downstream stage of the cell_F column array. Combines per-column tag_cell match lines into a
//  row-wise tag, accumulates it over a multi-cycle compare sequence, and resolves the match count
//  and first responder. It then drives the registered tag vector back into the cell_F tag inputs
//  for the write pass. Rows whose tag is 0 are never written by the array.
// PARAMETERS
//  DATA_DEPTH  4  rows per column; width of tag and of each column's tag_cell
//  NUM_COLS    8  number of cell_F columns feeding tag_cell_bus
//  CNT_W       3  match-count width; must satisfy 2**CNT_W > DATA_DEPTH
// PORTS
//  clk           in   1                    system clock, rising edge
//  rst_In        in   1                    asynchronous reset, active-high
//  tag_cell_bus  in   NUM_COLS*DATA_DEPTH  column c row r at bit [c*DATA_DEPTH+r]
//  cmp_valid     in   1                    tag_cell_bus holds a valid compare result this cycle
//  cmp_last      in   1                    qualifies cmp_valid: last compare of the sequence
//  wr_done       in   1                    array finished the write pass using tag
//  abort         in   1                    synchronous cancel of the current sequence
//  tag           out  DATA_DEPTH           registered row tag to cell_F; nonzero only in HOLD
//  busy          out  1                    FSM not in IDLE
//  match_any     out  1                    OR of the resolved tag; valid in HOLD
//  match_cnt     out  CNT_W                popcount of the resolved tag; valid in HOLD
//  first_idx     out  CNT_W                lowest row index with tag=1; 0 if none
//  done          out  1                    one-cycle pulse on HOLD->IDLE
// BEHAVIOUR
//  - Reset (async, rst_In=1): state=IDLE. acc, tag, match_any, match_cnt, first_idx, done,
//    busy all 0.
//  - row_match[r] = AND over c of tag_cell_bus[c*DATA_DEPTH+r]. Purely combinational, never
//    registered alone.
//  - FSM states: IDLE, CMP, RESOLVE, HOLD.
//  - IDLE:
//      cmp_valid & !cmp_last -> acc<=row_match, go CMP.
//      cmp_valid & cmp_last  -> acc<=row_match, go RESOLVE (single-compare sequence).
//  - CMP: each cmp_valid updates acc (see CONFIGURATION).
//      cmp_valid & cmp_last -> RESOLVE.
//      Cycles without cmp_valid hold acc and state.
//  - RESOLVE: one cycle. Registers match_cnt=popcount(acc), match_any=|acc,
//    first_idx=lowest set index. Next state HOLD.
//  - HOLD: tag=acc (registered, stable), busy=1. Inputs cmp_valid and cmp_last are ignored.
//    wr_done -> done pulse for 1 cycle, tag<=0, acc<=0, go IDLE.
//  - Latency: last cmp_valid at cycle N -> tag/match_* valid at N+2. wr_done at M -> done at M+1,
//    and tag=0 from M+1.
//  - tag is 0 in all states except HOLD. This guarantees no spurious cell_F writes during compare.
//  - match_cnt and first_idx hold their last value outside HOLD until the next RESOLVE.
//  - abort (any state): next cycle state=IDLE, acc=0, tag=0, no done pulse.
//    abort has priority over cmp_valid and wr_done in the same cycle.
//  - cmp_last without cmp_valid is ignored.
//  - Zero matches: HOLD is still entered, match_any=0, first_idx=0. wr_done is still required.
// CONFIGURATION
//  - TAG_ACCUM_EN defined: in CMP, acc <= acc | row_match. Multiple compare patterns
//    (e.g. several truth-table entries of one add pass) tag a row if any matched.
//  - TAG_ACCUM_EN undefined: in CMP, acc <= row_match. The last compare of the sequence alone
//    decides the tag.
//  - The first compare (from IDLE) always loads acc <= row_match in both builds.
// TESTING
//  1. Reset mid-HOLD (tag=4'b1010): assert rst_In -> tag=0, busy=0, done=0 immediately,
//     without a clock edge.
//  2. One-shot compare, NUM_COLS=8, all columns give row mask 4'b0110 with cmp_valid&cmp_last
//     -> 2 cycles later tag=4'b0110, match_cnt=2, first_idx=1, match_any=1.
//  3. Column disagreement: col0 gives 4'b1111, others give 4'b0101 -> resolved tag=4'b0101.
//  4. Three compares 4'b0001, 4'b0100, 4'b0000 (last) -> TAG_ACCUM_EN: tag=4'b0101,
//     match_cnt=2. Without the macro: tag=4'b0000, match_any=0, first_idx=0.
//  5. In HOLD, pulse wr_done -> done=1 for exactly one cycle, tag=0 and busy=0 the next cycle.
//     A cmp_valid issued during HOLD has no effect.
//  6. abort together with cmp_valid&cmp_last in CMP -> IDLE next cycle, no RESOLVE,
//     tag stays 0, no done.

Source files
------------

// File: rtl/ap_tag_resolver_if.sv
// Bundle of compare/tag signals between the cell_F column array (master) and ap_tag_resolver (slave).
interface ap_tag_resolver_if #(
  parameter int DATA_DEPTH = 4,
  parameter int NUM_COLS   = 8,
  parameter int CNT_W      = 3
);
  logic [NUM_COLS*DATA_DEPTH-1:0] tag_cell_bus;
  logic                           cmp_valid;
  logic                           cmp_last;
  logic                           wr_done;
  logic                           abort;
  logic [DATA_DEPTH-1:0]          tag;
  logic                           busy;
  logic                           match_any;
  logic [CNT_W-1:0]               match_cnt;
  logic [CNT_W-1:0]               first_idx;
  logic                           done;

  modport master (
    output tag_cell_bus, cmp_valid, cmp_last, wr_done, abort,
    input  tag, busy, match_any, match_cnt, first_idx, done
  );

  modport slave (
    input  tag_cell_bus, cmp_valid, cmp_last, wr_done, abort,
    output tag, busy, match_any, match_cnt, first_idx, done
  );
endinterface

// File: rtl/ap_tag_resolver.sv
// Row-tag resolver for the cell_F column array: ANDs column match lines, accumulates over a compare
// sequence, resolves count/first responder and holds the tag for the write pass. Option: TAG_ACCUM_EN.
module ap_tag_resolver #(
  parameter int DATA_DEPTH = 4,
  parameter int NUM_COLS   = 8,
  parameter int CNT_W      = 3
) (
  input  logic               clk,
  input  logic               rst_In,
  ap_tag_resolver_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMP     = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [DATA_DEPTH-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = {CNT_W{1'b0}};
    for (int i = 0; i < DATA_DEPTH; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  // Scan from the top so the lowest set row wins; 0 when nothing is set.
  function automatic logic [CNT_W-1:0] lowest_set(input logic [DATA_DEPTH-1:0] v);
    logic [CNT_W-1:0] idx;
    idx = {CNT_W{1'b0}};
    for (int i = DATA_DEPTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = CNT_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_t                state_r, state_nxt_s;
  logic [DATA_DEPTH-1:0] row_match_s;
  logic [DATA_DEPTH-1:0] acc_r, acc_nxt_s;
  logic [DATA_DEPTH-1:0] tag_r, tag_nxt_s;
  logic                  match_any_r, match_any_nxt_s;
  logic [CNT_W-1:0]      match_cnt_r, match_cnt_nxt_s;
  logic [CNT_W-1:0]      first_idx_r, first_idx_nxt_s;
  logic                  done_r, done_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic [DATA_DEPTH-1:0] acc_cmp_s;

  // A row matches only when every column reports a match for it.
  always_comb begin
    row_match_s = {DATA_DEPTH{1'b1}};
    for (int r = 0; r < DATA_DEPTH; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        row_match_s[r] = row_match_s[r] & bus.tag_cell_bus[c*DATA_DEPTH+r];
      end
    end
  end

`ifdef TAG_ACCUM_EN
  // Later compares of a sequence add rows to the tag.
  always_comb begin
    acc_cmp_s = acc_r | row_match_s;
  end
`else
  // Later compares of a sequence replace the tag.
  always_comb begin
    acc_cmp_s = row_match_s;
  end
`endif

  // Next-state and next-output logic; abort overrides everything else.
  always_comb begin
    state_nxt_s     = state_r;
    acc_nxt_s       = acc_r;
    tag_nxt_s       = tag_r;
    match_any_nxt_s = match_any_r;
    match_cnt_nxt_s = match_cnt_r;
    first_idx_nxt_s = first_idx_r;
    done_nxt_s      = 1'b0;
    if (bus.abort) begin
      state_nxt_s = ST_IDLE;
      acc_nxt_s   = {DATA_DEPTH{1'b0}};
      tag_nxt_s   = {DATA_DEPTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.cmp_valid) begin
            acc_nxt_s   = row_match_s;
            state_nxt_s = bus.cmp_last ? ST_RESOLVE : ST_CMP;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_CMP: begin
          if (bus.cmp_valid) begin
            acc_nxt_s   = acc_cmp_s;
            state_nxt_s = bus.cmp_last ? ST_RESOLVE : ST_CMP;
          end else begin
            state_nxt_s = ST_CMP;
          end
        end
        ST_RESOLVE: begin
          match_cnt_nxt_s = popcount(acc_r);
          match_any_nxt_s = |acc_r;
          first_idx_nxt_s = lowest_set(acc_r);
          tag_nxt_s       = acc_r;
          state_nxt_s     = ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.wr_done) begin
            done_nxt_s  = 1'b1;
            tag_nxt_s   = {DATA_DEPTH{1'b0}};
            acc_nxt_s   = {DATA_DEPTH{1'b0}};
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          acc_nxt_s   = {DATA_DEPTH{1'b0}};
          tag_nxt_s   = {DATA_DEPTH{1'b0}};
        end
      endcase
    end
    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst_In) begin
    if (rst_In) begin
      state_r     <= ST_IDLE;
      acc_r       <= {DATA_DEPTH{1'b0}};
      tag_r       <= {DATA_DEPTH{1'b0}};
      match_any_r <= 1'b0;
      match_cnt_r <= {CNT_W{1'b0}};
      first_idx_r <= {CNT_W{1'b0}};
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      tag_r       <= tag_nxt_s;
      match_any_r <= match_any_nxt_s;
      match_cnt_r <= match_cnt_nxt_s;
      first_idx_r <= first_idx_nxt_s;
      done_r      <= done_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  assign bus.tag       = tag_r;
  assign bus.busy      = busy_r;
  assign bus.match_any = match_any_r;
  assign bus.match_cnt = match_cnt_r;
  assign bus.first_idx = first_idx_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_ap_tag_resolver.sv
// Scoreboard bench for ap_tag_resolver; expected tag results are queued when the last compare is driven.
module tb_ap_tag_resolver;

  localparam int DD = 4;
  localparam int NC = 8;
  localparam int CW = 3;
`ifdef TAG_ACCUM_EN
  localparam bit ACCUM = 1'b1;
`else
  localparam bit ACCUM = 1'b0;
`endif

  typedef struct packed {
    logic [DD-1:0] tag;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;
    logic          any;
  } exp_t;

  logic clk;
  logic rst_In;
  int   n_vec;
  int   n_err;
  exp_t sb_q[$];
  exp_t last_e;

  ap_tag_resolver_if #(.DATA_DEPTH(DD), .NUM_COLS(NC), .CNT_W(CW)) bus_if ();

  ap_tag_resolver #(.DATA_DEPTH(DD), .NUM_COLS(NC), .CNT_W(CW)) dut (
    .clk    (clk),
    .rst_In (rst_In),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, obs, exp_v, $time);
    end
  endtask

  function automatic logic [DD-1:0] row_and(input logic [NC*DD-1:0] b);
    logic [DD-1:0] v;
    for (int r = 0; r < DD; r++) begin
      v[r] = 1'b1;
      for (int c = 0; c < NC; c++) v[r] = v[r] & b[c*DD+r];
    end
    return v;
  endfunction

  function automatic logic [NC*DD-1:0] mk_bus(input logic [DD-1:0] col0, input logic [DD-1:0] others);
    return {{(NC-1){others}}, col0};
  endfunction

  function automatic exp_t mk_exp(input logic [DD-1:0] m);
    exp_t e;
    e.tag = m;
    e.cnt = CW'($countones(m));
    e.any = |m;
    e.idx = '0;
    for (int r = DD - 1; r >= 0; r--) if (m[r]) e.idx = CW'(r);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmp(input logic [NC*DD-1:0] b, input logic last);
    bus_if.tag_cell_bus = b;
    bus_if.cmp_valid    = 1'b1;
    bus_if.cmp_last     = last;
    tick();
    bus_if.cmp_valid    = 1'b0;
    bus_if.cmp_last     = 1'b0;
    bus_if.tag_cell_bus = '0;
  endtask

  task automatic check_hold(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    last_e = e;
    chk({name, "_tag"},  32'(bus_if.tag),       32'(e.tag));
    chk({name, "_cnt"},  32'(bus_if.match_cnt), 32'(e.cnt));
    chk({name, "_idx"},  32'(bus_if.first_idx), 32'(e.idx));
    chk({name, "_any"},  32'(bus_if.match_any), 32'(e.any));
    chk({name, "_busy"}, 32'(bus_if.busy),      32'd1);
  endtask

  // Drive n compares (random idle gaps between them), model acc, then check the resolved HOLD outputs.
  task automatic run_seq(input string name, input logic [NC*DD-1:0] b[4], input int n, input bit gaps);
    logic [DD-1:0] acc_m;
    acc_m = '0;
    for (int i = 0; i < n; i++) begin
      if (i == 0) acc_m = row_and(b[i]);
      else        acc_m = ACCUM ? (acc_m | row_and(b[i])) : row_and(b[i]);
      if (i == n - 1) sb_q.push_back(mk_exp(acc_m));
      drive_cmp(b[i], i == n - 1);
      if (gaps && i != n - 1) repeat ($urandom_range(0, 2)) tick();
    end
    tick();
    check_hold(name);
  endtask

  task automatic finish_write(input string name);
    bus_if.wr_done = 1'b1;
    tick();
    bus_if.wr_done = 1'b0;
    chk({name, "_done1"}, 32'(bus_if.done), 32'd1);
    chk({name, "_tag0"},  32'(bus_if.tag),  32'd0);
    chk({name, "_idle"},  32'(bus_if.busy), 32'd0);
    tick();
    chk({name, "_done0"}, 32'(bus_if.done), 32'd0);
  endtask

  initial begin
    logic [NC*DD-1:0] b[4];
    logic [DD-1:0]    t;
    n_vec = 0;
    n_err = 0;
    rst_In = 1'b1;
    bus_if.tag_cell_bus = '0;
    bus_if.cmp_valid = 1'b0;
    bus_if.cmp_last  = 1'b0;
    bus_if.wr_done   = 1'b0;
    bus_if.abort     = 1'b0;
    tick();
    tick();
    chk("rst_tag",  32'(bus_if.tag),       32'd0);
    chk("rst_busy", 32'(bus_if.busy),      32'd0);
    chk("rst_done", 32'(bus_if.done),      32'd0);
    chk("rst_cnt",  32'(bus_if.match_cnt), 32'd0);
    chk("rst_idx",  32'(bus_if.first_idx), 32'd0);
    chk("rst_any",  32'(bus_if.match_any), 32'd0);
    rst_In = 1'b0;
    tick();

    // One-shot compare, all columns 0110
    b[0] = mk_bus(4'b0110, 4'b0110);
    run_seq("oneshot", b, 1, 1'b0);
    // cmp_valid during HOLD is ignored
    bus_if.cmp_valid = 1'b1;
    bus_if.cmp_last  = 1'b1;
    bus_if.tag_cell_bus = {(NC*DD){1'b1}};
    tick();
    bus_if.cmp_valid = 1'b0;
    bus_if.cmp_last  = 1'b0;
    bus_if.tag_cell_bus = '0;
    tick();
    chk("holdign_tag",  32'(bus_if.tag),       32'h6);
    chk("holdign_cnt",  32'(bus_if.match_cnt), 32'd2);
    chk("holdign_busy", 32'(bus_if.busy),      32'd1);
    finish_write("oneshot");

    // Column disagreement
    b[0] = mk_bus(4'b1111, 4'b0101);
    run_seq("disagree", b, 1, 1'b0);
    finish_write("disagree");

    // Three compares, last one matches nothing
    b[0] = mk_bus(4'b0001, 4'b0001);
    b[1] = mk_bus(4'b0100, 4'b0100);
    b[2] = mk_bus(4'b0000, 4'b0000);
    run_seq("three", b, 3, 1'b0);
    chk("three_tag_lit", 32'(bus_if.tag), ACCUM ? 32'h5 : 32'h0);
    finish_write("three");

    // cmp_last alone in CMP must not end the sequence
    bus_if.tag_cell_bus = mk_bus(4'b0011, 4'b0011);
    bus_if.cmp_valid = 1'b1;
    tick();
    bus_if.cmp_valid = 1'b0;
    bus_if.cmp_last  = 1'b1;
    tick();
    bus_if.cmp_last  = 1'b0;
    tick();
    tick();
    chk("lastonly_tag",  32'(bus_if.tag),  32'd0);
    chk("lastonly_busy", 32'(bus_if.busy), 32'd1);
    t = ACCUM ? 4'b1011 : 4'b1000;
    sb_q.push_back(mk_exp(t));
    drive_cmp(mk_bus(4'b1000, 4'b1000), 1'b1);
    tick();
    check_hold("lastonly");
    finish_write("lastonly");

    // abort beats cmp_valid&cmp_last in CMP
    drive_cmp(mk_bus(4'b0010, 4'b0010), 1'b0);
    bus_if.abort = 1'b1;
    drive_cmp(mk_bus(4'b0010, 4'b0010), 1'b1);
    bus_if.abort = 1'b0;
    chk("abort_busy", 32'(bus_if.busy), 32'd0);
    chk("abort_tag",  32'(bus_if.tag),  32'd0);
    tick();
    chk("abort_tag2",  32'(bus_if.tag),       32'd0);
    chk("abort_busy2", 32'(bus_if.busy),      32'd0);
    chk("abort_done",  32'(bus_if.done),      32'd0);
    chk("abort_cnt",   32'(bus_if.match_cnt), 32'(last_e.cnt));
    tick();
    chk("abort_done2", 32'(bus_if.done),      32'd0);

    // abort beats wr_done in HOLD
    b[0] = mk_bus(4'b1100, 4'b1100);
    run_seq("holdabort", b, 1, 1'b0);
    bus_if.abort   = 1'b1;
    bus_if.wr_done = 1'b1;
    tick();
    bus_if.abort   = 1'b0;
    bus_if.wr_done = 1'b0;
    chk("holdabort_done", 32'(bus_if.done), 32'd0);
    chk("holdabort_tag",  32'(bus_if.tag),  32'd0);
    chk("holdabort_busy", 32'(bus_if.busy), 32'd0);

    // Random sequences
    for (int s = 0; s < 24; s++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) begin
        t = 4'($urandom);
        for (int c = 0; c < NC; c++) begin
          b[i][c*DD +: DD] = t | (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
        end
      end
      run_seq("rand", b, n, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
      chk("rand_hold_tag", 32'(bus_if.tag), 32'(last_e.tag));
      finish_write("rand");
    end

    // Async reset mid-HOLD
    b[0] = mk_bus(4'b1010, 4'b1010);
    run_seq("rsthold", b, 1, 1'b0);
    @(negedge clk);
    rst_In = 1'b1;
    #1;
    chk("arst_tag",  32'(bus_if.tag),       32'd0);
    chk("arst_busy", 32'(bus_if.busy),      32'd0);
    chk("arst_done", 32'(bus_if.done),      32'd0);
    chk("arst_cnt",  32'(bus_if.match_cnt), 32'd0);
    tick();
    rst_In = 1'b0;
    tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
